icache_dm: RTL
==============

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter NumLines, default 8, number of cache lines (power of two, >=2).
REQ-002 SHALL have parameter WordsPerLine, default 4, 32-bit words per line (power of two, >=2).
REQ-003 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports: PCF  input  DPW  fetch byte address, bits [1:0] ignored.
REQ-006 SHALL have ports: flush  input  1  invalidate all lines.
REQ-007 SHALL have ports: instr  output  DPW  fetched instruction; stall  output  1  fetch not yet valid.
REQ-008 SHALL have ports: mem_req  output  1; mem_addr  output  DPW  word-aligned refill address.
REQ-009 SHALL have ports: mem_ack  input  1; mem_rdata  input  DPW  refill word, valid when mem_ack=1.

Function
REQ-010 SHALL be direct-mapped: offset = log2(WordsPerLine)+2 bits, index = log2(NumLines) bits, tag = remaining upper bits of PCF.
REQ-011 SHALL flag a hit combinationally when state=IDLE, valid[index]=1 and stored tag equals PCF tag.
REQ-012 On hit, instr SHALL equal the addressed word and stall SHALL be 0 in the same cycle (zero-latency hit).
REQ-013 On any non-hit cycle, stall SHALL be 1 and instr SHALL equal NOP 32'h0000_0013.
REQ-014 FSM states SHALL be IDLE and REFILL; IDLE->REFILL on miss with flush=0; REFILL->IDLE after final word acked or on flush.
REQ-015 On IDLE->REFILL, SHALL latch line base address (PCF with offset bits zeroed) and clear a word counter.
REQ-016 In REFILL, mem_req SHALL be 1 and mem_addr SHALL equal latched base + 4*counter, held stable until mem_ack.
REQ-017 On each mem_ack in REFILL, SHALL write mem_rdata to word[counter] and increment counter; back-to-back acks allowed.
REQ-018 On ack of word WordsPerLine-1, SHALL set valid and tag for the line and return to IDLE; hit possible next cycle.
REQ-019 Miss penalty SHALL be exactly WordsPerLine+1 cycles with mem_ack tied high.
REQ-020 PCF change during REFILL SHALL NOT alter the latched refill; the new PCF is looked up on return to IDLE.
REQ-021 flush SHALL clear all valid bits at the next edge; in REFILL it SHALL abort to IDLE, line left invalid.
REQ-022 flush coincident with mem_ack SHALL discard the word; mem_req SHALL be 0 in the following cycle.
REQ-023 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-024 rst_n=0 at an edge SHALL set state IDLE, all valid 0, counter 0; mem_req therefore 0 and mem_addr 0.
REQ-025 After reset every lookup SHALL miss (stall=1, instr=NOP) until refilled; reset mid-refill aborts with no line marked valid.
REQ-026 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-027 With macro ICACHE_STATS_EN defined, SHALL add outputs hit_cnt and miss_cnt (32-bit, reset 0, saturating at all-ones).
REQ-028 hit_cnt SHALL increment once per hit cycle; miss_cnt once per IDLE->REFILL transition.
REQ-029 Without ICACHE_STATS_EN, ports and counters SHALL be absent; remaining behaviour identical.

Structure
REQ-030 rv32i_pkg SHALL hold DPW, the NOP constant, and the FSM state enum typedef icache_state_e.
REQ-031 Tag/valid/data storage SHALL be sub-module icache_line_ram (indexed read, word write, valid clear-all); FSM stays in icache_dm.

Verification (NumLines=8, WordsPerLine=4)
REQ-032 After reset, PCF=0x04 -> stall=1, mem_addr 0x00,0x04,0x08,0x0C with immediate acks, then instr=rdata of 0x04, stall=0.
REQ-033 Line 0 filled; PCF=0x80 (same index, tag 1) -> miss, refill 0x80..0x8C; then PCF=0x00 -> miss again.
REQ-034 mem_ack low for 3 cycles per word -> mem_addr stable, mem_req held, total miss penalty 17 cycles.
REQ-035 flush asserted with 2nd ack of refill -> IDLE next cycle, mem_req=0, same PCF misses and refills from 0x00.
REQ-036 PCF changed 0x04->0x20 mid-refill -> refill of 0x00 completes, then refill of 0x20 line starts.
REQ-037 ICACHE_STATS_EN: 1 miss + 5 hit cycles -> miss_cnt=1, hit_cnt=5; rst_n=0 -> both 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-path definitions: datapath width, NOP encoding and the
// instruction-cache FSM state type.
package rv32i_pkg;

   localparam int unsigned DPW = 32;
   localparam logic [DPW-1:0] NOP = 32'h0000_0013;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } icache_state_e;

endpackage

// File: rtl/icache_line_ram.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Combinational indexed read, single-word write, per-line valid set and a
// clear-all for flush. Only the valid bits are reset.
module icache_line_ram
   import rv32i_pkg::*;
#(
   parameter int unsigned NumLines     = 8,
   parameter int unsigned WordsPerLine = 4,
   parameter int unsigned TagW         = 25,
   localparam int unsigned IdxW        = $clog2(NumLines),
   localparam int unsigned WOffW       = $clog2(WordsPerLine)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IdxW-1:0]  rd_index,
   input  logic [WOffW-1:0] rd_word,
   output logic             rd_valid,
   output logic [TagW-1:0]  rd_tag,
   output logic [DPW-1:0]   rd_data,
   input  logic             wr_en,
   input  logic [IdxW-1:0]  wr_index,
   input  logic [WOffW-1:0] wr_word,
   input  logic [DPW-1:0]   wr_data,
   input  logic             set_valid,
   input  logic [TagW-1:0]  set_tag,
   input  logic             clr_all
);

   logic [NumLines-1:0] valid_q;
   logic [TagW-1:0]     tag_q  [NumLines];
   logic [DPW-1:0]      data_q [NumLines*WordsPerLine];

   // Valid bits: reset and flush clear all lines; flush wins over a line fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (clr_all) begin
         valid_q <= '0;
      end else if (set_valid) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Data words and tags: plain storage, meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[{wr_index, wr_word}] <= wr_data;
      end
      if (set_valid) begin
         tag_q[wr_index] <= set_tag;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with zero-latency hits and a word-serial
// refill FSM (IDLE/REFILL).
// Optional feature: define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt.
module icache_dm
   import rv32i_pkg::*;
#(
   parameter int unsigned NumLines     = 8,
   parameter int unsigned WordsPerLine = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [DPW-1:0] PCF,
   input  logic           flush,
   output logic [DPW-1:0] instr,
   output logic           stall,
   output logic           mem_req,
   output logic [DPW-1:0] mem_addr,
   input  logic           mem_ack,
   input  logic [DPW-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]    hit_cnt,
   output logic [31:0]    miss_cnt
`endif
);

   localparam int unsigned WOffW = $clog2(WordsPerLine);
   localparam int unsigned OffW  = WOffW + 2;
   localparam int unsigned IdxW  = $clog2(NumLines);
   localparam int unsigned TagW  = DPW - OffW - IdxW;
   localparam logic [WOffW-1:0] LastWord = WOffW'(WordsPerLine - 1);

   icache_state_e    state_q, state_d;
   logic [DPW-1:0]   base_q, base_d;
   logic [WOffW-1:0] cnt_q, cnt_d;

   logic             rd_valid;
   logic [TagW-1:0]  rd_tag;
   logic [DPW-1:0]   rd_data;
   logic             wr_en;
   logic             set_valid;
   logic             hit;
   logic             unused_pcf_lsbs;

   assign unused_pcf_lsbs = ^PCF[1:0];

   icache_line_ram #(
      .NumLines     (NumLines),
      .WordsPerLine (WordsPerLine),
      .TagW         (TagW)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (PCF[OffW +: IdxW]),
      .rd_word   (PCF[2 +: WOffW]),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_index  (base_q[OffW +: IdxW]),
      .wr_word   (cnt_q),
      .wr_data   (mem_rdata),
      .set_valid (set_valid),
      .set_tag   (base_q[DPW-1 -: TagW]),
      .clr_all   (flush)
   );

   assign hit      = (state_q == IDLE) && rd_valid && (rd_tag == PCF[DPW-1 -: TagW]);
   assign instr    = hit ? rd_data : NOP;
   assign stall    = !hit;
   assign mem_req  = (state_q == REFILL);
   assign mem_addr = mem_req ? (base_q + (DPW'(cnt_q) << 2)) : '0;

   // FSM state, latched line base and refill word counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and RAM write control; a flush discards any coincident ack.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;
      set_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!hit && !flush) begin
               state_d = REFILL;
               base_d  = {PCF[DPW-1:OffW], {OffW{1'b0}}};
               cnt_d   = '0;
            end
         end
         REFILL: begin
            if (flush) begin
               state_d = IDLE;
            end else if (mem_ack) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastWord) begin
                  set_valid = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ICACHE_STATS_EN
   // Saturating hit/miss statistics; a miss is counted on entry to REFILL.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if ((state_q == IDLE) && (state_d == REFILL) && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
